// File: rtl/video_frame_capture.sv
// rtl/video_frame_capture.sv - raster stream sink: frame lock, linear frame-buffer writes, geometry checks
module video_frame_capture #(
  parameter string MODE        = "GRAYSCALE",
  parameter int    IMG_WIDTH   = 640,
  parameter int    IMG_HEIGHT  = 480,
  parameter int    PIXEL_WIDTH = 8,
  parameter int    ADDR_WIDTH  = 19
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_enable,
  input  logic                     i_err_clr,
  input  logic                     i_vsync,
  input  logic                     i_hsync,
  input  logic                     i_data_valid,
  input  logic [PIXEL_WIDTH-1:0]   i_data_r,
  input  logic [PIXEL_WIDTH-1:0]   i_data_g,
  input  logic [PIXEL_WIDTH-1:0]   i_data_b,
  output logic                     o_wr_en,
  output logic [ADDR_WIDTH-1:0]    o_wr_addr,
  output logic [3*PIXEL_WIDTH-1:0] o_wr_data,
  output logic                     o_frame_done,
  output logic [15:0]              o_frame_cnt,
  output logic                     o_busy,
  output logic [3:0]               o_err_flags
);

  localparam int CW = 16;
  localparam bit RGB_MODE = (MODE == "RGB");
  localparam logic [CW-1:0] W_C = CW'(IMG_WIDTH);
  localparam logic [CW-1:0] H_C = CW'(IMG_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(IMG_WIDTH);

  typedef enum logic [1:0] {IDLE, SYNC, ARMED, CAPTURE} state_t;

  state_t                   state_q, state_d;
  logic                     vsync_q, valid_q;
  logic [CW-1:0]            x_q, x_d, y_q, y_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d, base_q, base_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
  logic [3*PIXEL_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                     frame_done_q, frame_done_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;
  logic [3:0]               err_q, err_d, err_set;

  logic          vs_rise, vs_fall, val_fall, line_end;
  logic [CW-1:0] x_inc, y_inc, lines_seen;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    base_d       = base_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    err_set      = 4'b0000;

    vs_rise    = i_vsync & ~vsync_q;
    vs_fall    = ~i_vsync & vsync_q;
    val_fall   = ~i_data_valid & valid_q;
    line_end   = (state_q == CAPTURE) & val_fall;
    // Saturating counters keep a runaway stream from wrapping back into range.
    x_inc      = (x_q == '1) ? x_q : x_q + 1'b1;
    y_inc      = (y_q == '1) ? y_q : y_q + 1'b1;
    lines_seen = line_end ? y_inc : y_q;

    if (i_data_valid && (i_vsync || i_hsync) && state_q != IDLE) err_set[2] = 1'b1;

    case (state_q)
      IDLE: begin
        if (i_enable) state_d = SYNC;
      end
      SYNC: begin
        if (!i_enable)    state_d = IDLE;
        else if (i_vsync) state_d = ARMED;
      end
      ARMED: begin
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
        base_d = '0;
        if (!i_enable)    state_d = IDLE;
        else if (vs_fall) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (i_data_valid) begin
          if (x_q < W_C && y_q < H_C) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = RGB_MODE ? {i_data_r, i_data_g, i_data_b}
                                 : {{(2*PIXEL_WIDTH){1'b0}}, i_data_r};
          end else begin
            err_set[3] = 1'b1;
          end
          x_d    = x_inc;
          addr_d = addr_q + 1'b1;
        end
        if (line_end) begin
          if (x_q != W_C) err_set[0] = 1'b1;
          x_d    = '0;
          y_d    = y_inc;
          base_d = base_q + LINE_STEP;
          addr_d = base_q + LINE_STEP;
        end
        // A line ending in the same cycle as vsync rising still counts here.
        if (vs_rise) begin
          if (lines_seen != H_C) err_set[1] = 1'b1;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          state_d      = i_enable ? ARMED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    err_d = (i_err_clr ? 4'b0000 : err_q) | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b1;
      valid_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      base_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= i_vsync;
      valid_q      <= i_data_valid;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      base_q       <= base_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_frame_done = frame_done_q;
  assign o_frame_cnt  = frame_cnt_q;
  assign o_busy       = (state_q == CAPTURE);
  assign o_err_flags  = err_q;

endmodule

// File: tb/tb_video_frame_capture.sv
// tb/tb_video_frame_capture.sv - randomized raster stimulus with write scoreboard for video_frame_capture
module tb_video_frame_capture;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int PW = 8;
  localparam int AW = 5;
  localparam int HB = 4;
  localparam int VB = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_enable, i_err_clr, i_vsync, i_hsync, i_data_valid;
  logic [PW-1:0] i_data_r, i_data_g, i_data_b;
  logic          o_wr_en, o_frame_done, o_busy;
  logic [AW-1:0] o_wr_addr;
  logic [3*PW-1:0] o_wr_data;
  logic [15:0]   o_frame_cnt;
  logic [3:0]    o_err_flags;

  always #5 clk = ~clk;

  video_frame_capture #(
    .MODE("RGB"), .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_err_clr(i_err_clr),
    .i_vsync(i_vsync), .i_hsync(i_hsync), .i_data_valid(i_data_valid),
    .i_data_r(i_data_r), .i_data_g(i_data_g), .i_data_b(i_data_b),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt),
    .o_busy(o_busy), .o_err_flags(o_err_flags)
  );

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [3*PW-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  int   exp_cnt = 0;
  int   exp_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (o_frame_done) done_cnt++;
    if (o_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h with nothing expected", o_wr_addr, o_wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(o_wr_addr), int'(e.addr));
        chk("wr_data", int'(o_wr_data), int'(e.data));
      end
    end
  end

  task automatic drive(input logic vs, input logic hs, input logic dv);
    @(posedge clk);
    #1;
    i_vsync      = vs;
    i_hsync      = hs;
    i_data_valid = dv;
    i_data_r     = PW'($urandom);
    i_data_g     = PW'($urandom);
    i_data_b     = PW'($urandom);
  endtask

  task automatic vblank();
    for (int i = 0; i < VB * (W + HB); i++) drive(1'b1, 1'b1, 1'b0);
  endtask

  // Expected writes come straight from raster geometry: line l, pixel p -> l*W+p when inside the image.
  task automatic send_frame(input int n_lines, input int short_line, input int short_len,
                            input bit cap, input int en_on_line, input int en_off_line,
                            input int rst_pix, input bit tail);
    int  idx = 0;
    int  len;
    bit  bad_len = 1'b0;
    bit  oob = 1'b0;
    wr_t w;
    for (int l = 0; l < n_lines; l++) begin
      if (l == en_on_line)  i_enable = 1'b1;
      if (l == en_off_line) i_enable = 1'b0;
      len = (l == short_line) ? short_len : W;
      if (len != W) bad_len = 1'b1;
      for (int h = 0; h < HB; h++) drive(1'b0, 1'b1, 1'b0);
      for (int p = 0; p < len; p++) begin
        drive(1'b0, 1'b0, 1'b1);
        if (idx == rst_pix) begin
          rst_n = 1'b0;
          #1;
          chk("rst_wr_en", int'(o_wr_en), 0);
          chk("rst_frame_cnt", int'(o_frame_cnt), 0);
          chk("rst_busy", int'(o_busy), 0);
          chk("rst_err", int'(o_err_flags), 0);
          exp_cnt = 0;
          exp_err = 0;
        end
        if (rst_pix >= 0 && idx == rst_pix + 2) rst_n = 1'b1;
        if (cap && l < H && p < W && (rst_pix < 0 || idx < rst_pix - 1)) begin
          w.addr = AW'(l * W + p);
          w.data = {i_data_r, i_data_g, i_data_b};
          exp_q.push_back(w);
        end
        if (l >= H || p >= W) oob = 1'b1;
        idx++;
      end
    end
    if (tail) for (int h = 0; h < HB; h++) drive(1'b0, 1'b1, 1'b0);
    if (cap && rst_pix < 0) begin
      if (bad_len)      exp_err = exp_err | 1;
      if (n_lines != H) exp_err = exp_err | 2;
      if (oob)          exp_err = exp_err | 8;
      exp_cnt = (exp_cnt + 1) % 65536;
      exp_done++;
    end
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_pending_writes"}, exp_q.size(), 0);
    chk({tag, "_frame_cnt"}, int'(o_frame_cnt), exp_cnt);
    chk({tag, "_done_pulses"}, done_cnt, exp_done);
    chk({tag, "_err_flags"}, int'(o_err_flags), exp_err);
  endtask

  task automatic clear_err();
    i_err_clr = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    i_err_clr = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    exp_err = 0;
    chk("err_after_clr", int'(o_err_flags), 0);
  endtask

  initial begin
    rst_n = 1'b0; i_enable = 1'b0; i_err_clr = 1'b0;
    i_vsync = 1'b0; i_hsync = 1'b0; i_data_valid = 1'b0;
    i_data_r = '0; i_data_g = '0; i_data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_en", int'(o_wr_en), 0);
    chk("reset_wr_addr", int'(o_wr_addr), 0);
    chk("reset_wr_data", int'(o_wr_data), 0);
    chk("reset_frame_cnt", int'(o_frame_cnt), 0);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_err", int'(o_err_flags), 0);
    rst_n = 1'b1;

    // Clean frame
    i_enable = 1'b1;
    vblank();
    send_frame(H, -1, W, 1'b1, -1, -1, -1, 1'b1);
    chk("busy_in_frame", int'(o_busy), 1);
    vblank();
    checkpoint("clean");
    chk("busy_after_frame", int'(o_busy), 0);

    // Enable raised mid-frame: that frame is skipped
    i_enable = 1'b0;
    vblank();
    send_frame(H, -1, W, 1'b0, 1, -1, -1, 1'b1);
    vblank();
    send_frame(H, -1, W, 1'b1, -1, -1, -1, 1'b1);
    vblank();
    checkpoint("mid_enable");

    // Truncated line
    send_frame(H, 2, W - 1, 1'b1, -1, -1, -1, 1'b1);
    vblank();
    checkpoint("short_line");
    clear_err();

    // One line too many
    send_frame(H + 1, -1, W, 1'b1, -1, -1, -1, 1'b1);
    vblank();
    checkpoint("tall_frame");
    clear_err();

    // Last line ends in the same cycle vsync rises
    send_frame(H, -1, W, 1'b1, -1, -1, -1, 1'b0);
    vblank();
    checkpoint("same_cycle_end");

    // Enable dropped mid-frame: frame completes, next one ignored
    send_frame(H, -1, W, 1'b1, -1, 2, -1, 1'b1);
    vblank();
    checkpoint("enable_drop");
    chk("idle_after_drop", int'(o_busy), 0);
    send_frame(H, -1, W, 1'b0, -1, -1, -1, 1'b1);
    vblank();
    checkpoint("ignored_frame");

    // Reset mid-frame, then resynchronise
    i_enable = 1'b1;
    vblank();
    send_frame(H, -1, W, 1'b1, -1, -1, 13, 1'b1);
    vblank();
    send_frame(H, -1, W, 1'b1, -1, -1, -1, 1'b1);
    vblank();
    checkpoint("after_reset");

    // Valid during blanking together with a clear: the new error survives
    drive(1'b1, 1'b1, 1'b1);
    i_err_clr = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    i_err_clr = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    exp_err = 4;
    chk("blank_valid_err", int'(o_err_flags), exp_err);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
